jk_exc_driver: RTL and testbench

- Driving end of the JK flip-flop interface: plays back a buffered sequence of target Q values.
- For each target, generates the J/K excitation that moves the attached JK flop from its current Q to that target.
- Reads back Q and checks every transition, reporting a mismatch count and the first failing index.
- Sits beside any JK_ff instance as a self-checking sequencer, either on-chip (built-in self test) or in benches.

---
 rtl/jk_pkg.sv | 18 +
 rtl/jk_exc_driver_if.sv | 29 ++
 rtl/jk_seq_buf.sv | 46 ++++
 rtl/jk_exc_driver.sv | 125 ++++++++++++
 tb/tb_jk_exc_driver.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: state encoding and the
// J/K excitation rule, which benches may also call.
package jk_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t FLUSH = 2'd2;
   localparam state_t DONE  = 2'd3;

   // Returns {J,K} moving a JK flop from q to tgt; don't-cares resolved to 0,
   // so toggle (J=K=1) never occurs.
   function automatic logic [1:0] jk_exc(input logic q, input logic tgt);
      return {~q & tgt, q & ~tgt};
   endfunction

endpackage

// File: rtl/jk_exc_driver_if.sv
// Control, status and flop-drive signals between a host and jk_exc_driver.
interface jk_exc_driver_if #(
   parameter int AW = 4,
   parameter int CW = 8
) ();
   logic          clr;
   logic          wr_en;
   logic          wr_data;
   logic          start;
   logic          q_fb;
   logic          J;
   logic          K;
   logic          busy;
   logic          done;
   logic          full;
   logic          err;
   logic [AW-1:0] err_idx;
   logic [CW-1:0] mismatch_cnt;

   modport master (
      output clr, wr_en, wr_data, start, q_fb,
      input  J, K, busy, done, full, err, err_idx, mismatch_cnt
   );

   modport slave (
      input  clr, wr_en, wr_data, start, q_fb,
      output J, K, busy, done, full, err, err_idx, mismatch_cnt
   );
endinterface

// File: rtl/jk_seq_buf.sv
// DEPTH x 1 target buffer: appended in order, read combinationally by pointer.
module jk_seq_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic          wr_data,
   input  logic [AW-1:0] rd_ptr,
   output logic          rd_data,
   output logic [AW:0]   count,
   output logic          full
);
   logic [DEPTH-1:0] mem_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW:0]      count_reg;
   logic             wr_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign wr_ok   = wr_en & ~full & ~clr;
   assign count   = count_reg;
   assign rd_data = mem_reg[rd_ptr];

   // Contents are don't-care after reset, so the storage has no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_reg[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (wr_ok) begin
         wr_ptr_reg <= wr_ptr_reg + 1'b1;
         count_reg  <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/jk_exc_driver.sv
// Plays back buffered target Q values into a JK flop via J/K excitation and
// checks each resulting Q two edges after its target was issued.
module jk_exc_driver
   import jk_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CW    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   jk_exc_driver_if.slave  bus
);
   state_t        state_reg, state_next;
   logic [AW-1:0] rd_ptr_reg;
   logic          exp_q_reg;
   logic [AW-1:0] exp_idx_reg;
   logic          exp_vld_reg;
   logic          err_reg;
   logic [AW-1:0] err_idx_reg;
   logic [CW-1:0] mm_cnt_reg;

   logic          tgt;
   logic [AW:0]   count;
   logic          full;
   logic          idle;
   logic          nonempty;
   logic          last_entry;
   logic          start_ok;
   logic          mismatch;

   assign idle = (state_reg == IDLE);

   jk_seq_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (idle & bus.clr),
      .wr_en   (idle & bus.wr_en),
      .wr_data (bus.wr_data),
      .rd_ptr  (rd_ptr_reg),
      .rd_data (tgt),
      .count   (count),
      .full    (full)
   );

   // A write landing on the start edge is part of the playback.
   assign nonempty   = ~bus.clr & ((count != '0) | bus.wr_en);
   assign start_ok   = idle & bus.start;
   assign last_entry = ({1'b0, rd_ptr_reg} == (count - {{AW{1'b0}}, 1'b1}));
   assign mismatch   = exp_vld_reg & (state_reg == RUN || state_reg == FLUSH)
                       & (bus.q_fb != exp_q_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = nonempty ? RUN : DONE;
         RUN:     if (last_entry) state_next = FLUSH;
         FLUSH:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      {bus.J, bus.K} = 2'b00;
      if (state_reg == RUN) begin
         {bus.J, bus.K} = jk_exc(bus.q_fb, tgt);
      end
      bus.busy = (state_reg == RUN) || (state_reg == FLUSH);
      bus.done = (state_reg == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg  <= '0;
         exp_q_reg   <= 1'b0;
         exp_idx_reg <= '0;
         exp_vld_reg <= 1'b0;
         err_reg     <= 1'b0;
         err_idx_reg <= '0;
         mm_cnt_reg  <= '0;
      end else begin
         if (start_ok) begin
            rd_ptr_reg  <= '0;
            exp_vld_reg <= 1'b0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
            mm_cnt_reg  <= '0;
         end
         if (state_reg == RUN) begin
            exp_q_reg   <= tgt;
            exp_idx_reg <= rd_ptr_reg;
            exp_vld_reg <= 1'b1;
            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
         end
         if (state_reg == FLUSH) begin
            exp_vld_reg <= 1'b0;
         end
         // Only the first failure records its index; the count keeps going.
         if (mismatch) begin
            if (mm_cnt_reg != '1) begin
               mm_cnt_reg <= mm_cnt_reg + 1'b1;
            end
            if (!err_reg) begin
               err_reg     <= 1'b1;
               err_idx_reg <= exp_idx_reg;
            end
         end
      end
   end

   assign bus.full         = full;
   assign bus.err          = err_reg;
   assign bus.err_idx      = err_idx_reg;
   assign bus.mismatch_cnt = mm_cnt_reg;

endmodule

// File: tb/tb_jk_exc_driver.sv
// Bench for jk_exc_driver with a behavioural JK flop on q_fb and a reference
// model that derives J/K, check results and done timing from the targets.
module tb_jk_exc_driver;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   logic q_ff;
   logic load_q, load_val;
   logic flip, force0;
   bit   tgt_a [17];
   bit   flip_m[17];

   jk_exc_driver_if #(.AW(4), .CW(8)) bus ();

   jk_exc_driver #(.DEPTH(16), .AW(4), .CW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural JK flop driven by the DUT.
   always @(posedge clk) begin
      if (load_q) q_ff <= load_val;
      else case ({bus.J, bus.K})
         2'b10:   q_ff <= 1'b1;
         2'b01:   q_ff <= 1'b0;
         2'b11:   q_ff <= ~q_ff;
         default: q_ff <= q_ff;
      endcase
   end

   assign bus.q_fb = force0 ? 1'b0 : (q_ff ^ flip);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit [1:0] exc_model(input bit q, input bit t);
      if (q == t) return 2'b00;
      return t ? 2'b10 : 2'b01;
   endfunction

   task automatic preset(input bit v);
      @(negedge clk);
      load_q = 1'b1; load_val = v;
      @(posedge clk); #1 load_q = 1'b0;
   endtask

   task automatic load(input int n);
      @(negedge clk); bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = tgt_a[i];
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
   endtask

   // Start playback of tgt_a[0..n-1]; with_wr appends the last entry on the start cycle.
   task automatic play(input int n, input bit with_wr, input string tag);
      bit mq, qfb, eerr;
      bit [1:0] ejk;
      int emm, eidx;
      mq = q_ff; emm = 0; eidx = 0; eerr = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      if (with_wr) begin bus.wr_en = 1'b1; bus.wr_data = tgt_a[n-1]; end
      @(posedge clk); #1 bus.start = 1'b0; bus.wr_en = 1'b0;
      for (int k = 0; k <= n; k++) begin
         flip = (k >= 1) ? flip_m[k-1] : 1'b0;
         qfb  = force0 ? 1'b0 : (mq ^ flip);
         if (k >= 1 && qfb != tgt_a[k-1]) begin
            if (!eerr) eidx = k - 1;
            eerr = 1'b1;
            emm++;
         end
         ejk = (k < n) ? exc_model(qfb, tgt_a[k]) : 2'b00;
         @(negedge clk);
         chk({tag, " jk"}, {30'd0, bus.J, bus.K}, {30'd0, ejk});
         chk({tag, " busy"}, 32'(bus.busy), 32'd1);
         chk({tag, " done_early"}, 32'(bus.done), 32'd0);
         if (ejk == 2'b10) mq = 1'b1;
         else if (ejk == 2'b01) mq = 1'b0;
         @(posedge clk); #1;
      end
      flip = 1'b0;
      @(negedge clk);
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, " jk_done"}, {30'd0, bus.J, bus.K}, 32'd0);
      chk({tag, " err"}, 32'(bus.err), 32'(eerr));
      chk({tag, " err_idx"}, 32'(bus.err_idx), 32'(eidx));
      chk({tag, " mm_cnt"}, 32'(bus.mismatch_cnt), 32'(emm));
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      $display("[TB] play %s n=%0d mismatches=%0d err_idx=%0d", tag, n, emm, eidx);
   endtask

   task automatic empty_start(input string tag);
      @(negedge clk); bus.start = 1'b1;
      chk({tag, " jk_start"}, {30'd0, bus.J, bus.K}, 32'd0);
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " jk"}, {30'd0, bus.J, bus.K}, 32'd0);
      chk({tag, " err"}, 32'(bus.err), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
      $display("[TB] empty start %s", tag);
   endtask

   initial begin
      rst_n = 1'b0; load_q = 1'b1; load_val = 1'b0; flip = 1'b0; force0 = 1'b0;
      bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 1'b0; bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 load_q = 1'b0;
      @(negedge clk);
      chk("rst jk", {30'd0, bus.J, bus.K}, 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst full", 32'(bus.full), 32'd0);
      chk("rst err", 32'(bus.err), 32'd0);
      chk("rst err_idx", 32'(bus.err_idx), 32'd0);
      chk("rst mm_cnt", 32'(bus.mismatch_cnt), 32'd0);
      rst_n = 1'b1;

      // Directed sequence 1,1,0,0,1 from Q=0, then a replay without reload.
      tgt_a[0] = 1; tgt_a[1] = 1; tgt_a[2] = 0; tgt_a[3] = 0; tgt_a[4] = 1;
      for (int i = 0; i < 17; i++) flip_m[i] = 1'b0;
      preset(1'b0); load(5); play(5, 1'b0, "basic");
      preset(1'b0); play(5, 1'b0, "replay");

      force0 = 1'b1; preset(1'b0); play(5, 1'b0, "forced0"); force0 = 1'b0;
      chk("forced0 total", 32'(bus.mismatch_cnt), 32'd3);

      // start on the same cycle as the final write
      for (int i = 0; i < 6; i++) tgt_a[i] = 1'($urandom_range(0, 1));
      preset(1'b0); load(5); play(6, 1'b1, "start_wr");

      // fill to 16, then a 17th write that must be ignored
      for (int i = 0; i < 16; i++) tgt_a[i] = 1'($urandom_range(0, 1));
      preset(1'b1); load(16);
      chk("full16", 32'(bus.full), 32'd1);
      bus.wr_en = 1'b1; bus.wr_data = ~tgt_a[0];
      @(negedge clk); bus.wr_en = 1'b0;
      chk("full17", 32'(bus.full), 32'd1);
      play(16, 1'b0, "full");

      for (int it = 0; it < 6; it++) begin
         int n;
         n = $urandom_range(1, 16);
         for (int i = 0; i < 17; i++) begin
            tgt_a[i]  = 1'($urandom_range(0, 1));
            flip_m[i] = ($urandom_range(0, 3) == 0);
         end
         preset(1'($urandom_range(0, 1))); load(n);
         play(n, 1'b0, $sformatf("rand%0d", it));
      end
      for (int i = 0; i < 17; i++) flip_m[i] = 1'b0;

      @(negedge clk); bus.clr = 1'b1;
      @(negedge clk); bus.clr = 1'b0;
      empty_start("empty");

      tgt_a[0] = 1; tgt_a[1] = 0; tgt_a[2] = 1;
      load(3);
      bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 1'b1;
      @(negedge clk); bus.clr = 1'b0; bus.wr_en = 1'b0;
      chk("clr_wr full", 32'(bus.full), 32'd0);
      empty_start("clr_wr");

      // reset during RUN while entry 2 is being driven
      tgt_a[0] = 1; tgt_a[1] = 1; tgt_a[2] = 0; tgt_a[3] = 0; tgt_a[4] = 1;
      preset(1'b0); load(5);
      @(negedge clk); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrun busy_before", 32'(bus.busy), 32'd1);
      chk("midrun jk_before", {30'd0, bus.J, bus.K}, 32'd1);
      rst_n = 1'b0; #1;
      chk("midrun jk", {30'd0, bus.J, bus.K}, 32'd0);
      chk("midrun busy", 32'(bus.busy), 32'd0);
      chk("midrun done", 32'(bus.done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrun no_done", 32'(bus.done), 32'd0);
      end
      empty_start("after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
